// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, constants, fclass bit positions and the
// decoded-operand record used by the FPU front end.
//   EXP_W / SIG_W  : exponent width and significand width (hidden bit + fraction)
//   EXP_ONES       : all-ones exponent marking inf / NaN
//   QNAN_CANON     : canonical quiet NaN; its top fraction bit is the quiet bit
//   CLS_*          : RISC-V fclass one-hot bit indices
package fpu_pkg;

   localparam int WORD_W  = 32;
   localparam int EXP_W   = 8;
   localparam int SIG_W   = 24;
   localparam int FRAC_W  = SIG_W - 1;
   localparam int CLASS_W = 10;

   localparam logic [EXP_W-1:0]  EXP_ONES   = '1;
   localparam logic [WORD_W-1:0] QNAN_CANON = 32'h7FC0_0000;

   localparam int CLS_NEG_INF  = 0;
   localparam int CLS_NEG_NORM = 1;
   localparam int CLS_NEG_SUB  = 2;
   localparam int CLS_NEG_ZERO = 3;
   localparam int CLS_POS_ZERO = 4;
   localparam int CLS_POS_SUB  = 5;
   localparam int CLS_POS_NORM = 6;
   localparam int CLS_POS_INF  = 7;
   localparam int CLS_SNAN     = 8;
   localparam int CLS_QNAN     = 9;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic               sign;
      logic [EXP_W-1:0]   exp;
      logic [SIG_W-1:0]   sig;
      logic               is_inf;
      logic               is_nan;
      logic               is_snan;
      logic               is_zero;
      logic               is_sub;
      logic [CLASS_W-1:0] cls;
   } op_dec_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational decode of one raw binary32 operand into sign, exponent,
// significand with hidden bit, classification flags and fclass mask.
//   op  : raw binary32 operand
//   dec : decoded fields (op_dec_t)
module fpu_classify
   import fpu_pkg::*;
(
   input  logic [WORD_W-1:0] op,
   output op_dec_t           dec
);

   logic [EXP_W-1:0]  exp;
   logic [FRAC_W-1:0] frac;
   logic              exp_max;
   logic              exp_min;
   logic              frac_zero;
   logic              sign;

   assign sign      = op[WORD_W-1];
   assign exp       = op[WORD_W-2 -: EXP_W];
   assign frac      = op[FRAC_W-1:0];
   assign exp_max   = (exp == EXP_ONES);
   assign exp_min   = (exp == '0);
   assign frac_zero = (frac == '0);

   always_comb begin
      dec         = '0;
      dec.sign    = sign;
      dec.exp     = exp;
      dec.sig     = {~exp_min, frac};
      dec.is_inf  = exp_max & frac_zero;
      dec.is_nan  = exp_max & ~frac_zero;
      // A NaN is signaling when its quiet bit differs from the canonical qNaN.
      dec.is_snan = exp_max & ~frac_zero & (frac[FRAC_W-1] != QNAN_CANON[FRAC_W-1]);
      dec.is_zero = exp_min & frac_zero;
      dec.is_sub  = exp_min & ~frac_zero;

      if (dec.is_snan)
         dec.cls[CLS_SNAN] = 1'b1;
      else if (dec.is_nan)
         dec.cls[CLS_QNAN] = 1'b1;
      else if (dec.is_inf)
         dec.cls[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
      else if (dec.is_zero)
         dec.cls[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
      else if (dec.is_sub)
         dec.cls[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
      else
         dec.cls[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
   end

endmodule

// File: rtl/fpu_operand_unpack.sv
// Operand unpack stage: decodes an A/B binary32 pair at the input and holds
// the decoded result in a 2-entry skid buffer. Every output is driven from
// the head entry register.
//   clk_i, reset_i (sync, active-high), flush_i (drop all entries)
//   valid_i/ready_o, op_a_i, op_b_i, tag_i : upstream handshake and payload
//   valid_o/ready_i                        : downstream handshake
//   sign/exp/sig/is_*/class _a_o/_b_o, is_signaling_o, tag_o : head entry
//
// state    | meaning
// ST_EMPTY | no entry buffered; valid_o low, ready_o high
// ST_ONE   | head entry valid, second slot free
// ST_TWO   | head and second entries valid; ready_o low
module fpu_operand_unpack
   import fpu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               flush_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WORD_W-1:0]  op_a_i,
   input  logic [WORD_W-1:0]  op_b_i,
   input  logic [TAG_W-1:0]   tag_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               sign_a_o,
   output logic               sign_b_o,
   output logic [EXP_W-1:0]   exp_a_o,
   output logic [EXP_W-1:0]   exp_b_o,
   output logic [SIG_W-1:0]   sig_a_o,
   output logic [SIG_W-1:0]   sig_b_o,
   output logic               is_inf_a_o,
   output logic               is_inf_b_o,
   output logic               is_nan_a_o,
   output logic               is_nan_b_o,
   output logic               is_zero_a_o,
   output logic               is_zero_b_o,
   output logic               is_sub_a_o,
   output logic               is_sub_b_o,
   output logic               is_signaling_o,
   output logic [CLASS_W-1:0] class_a_o,
   output logic [CLASS_W-1:0] class_b_o,
   output logic [TAG_W-1:0]   tag_o
);

   skid_state_e state_q, state_d;

   op_dec_t          dec_a, dec_b;
   op_dec_t          head_a_q, head_b_q, sec_a_q, sec_b_q;
   logic [TAG_W-1:0] head_tag_q, sec_tag_q;

   logic push, pop;
   logic head_ld_new, head_ld_sec, sec_ld;

   fpu_classify u_classify_a (.op(op_a_i), .dec(dec_a));
   fpu_classify u_classify_b (.op(op_b_i), .dec(dec_b));

   assign push = valid_i & ready_o;
   assign pop  = valid_o & ready_i;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (push) state_d = ST_ONE;
         ST_ONE: begin
            if (push && !pop)
               state_d = ST_TWO;
            else if (!push && pop)
               state_d = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush_i)
         state_d = ST_EMPTY;
   end

   always_comb begin
      valid_o = (state_q != ST_EMPTY);
      ready_o = (state_q != ST_TWO);
   end

   // Head takes the new pair when the buffer is empty or when it drains and
   // refills in the same cycle; otherwise a new pair parks in the second slot.
   assign head_ld_new = !flush_i & push &
                        ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & pop));
   assign sec_ld      = !flush_i & push & (state_q == ST_ONE) & !pop;
   assign head_ld_sec = !flush_i & pop & (state_q == ST_TWO);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_a_q   <= '0;
         head_b_q   <= '0;
         head_tag_q <= '0;
         sec_a_q    <= '0;
         sec_b_q    <= '0;
         sec_tag_q  <= '0;
      end else begin
         if (head_ld_new) begin
            head_a_q   <= dec_a;
            head_b_q   <= dec_b;
            head_tag_q <= tag_i;
         end else if (head_ld_sec) begin
            head_a_q   <= sec_a_q;
            head_b_q   <= sec_b_q;
            head_tag_q <= sec_tag_q;
         end
         if (sec_ld) begin
            sec_a_q   <= dec_a;
            sec_b_q   <= dec_b;
            sec_tag_q <= tag_i;
         end
      end
   end

   assign sign_a_o       = head_a_q.sign;
   assign sign_b_o       = head_b_q.sign;
   assign exp_a_o        = head_a_q.exp;
   assign exp_b_o        = head_b_q.exp;
   assign sig_a_o        = head_a_q.sig;
   assign sig_b_o        = head_b_q.sig;
   assign is_inf_a_o     = head_a_q.is_inf;
   assign is_inf_b_o     = head_b_q.is_inf;
   assign is_nan_a_o     = head_a_q.is_nan;
   assign is_nan_b_o     = head_b_q.is_nan;
   assign is_zero_a_o    = head_a_q.is_zero;
   assign is_zero_b_o    = head_b_q.is_zero;
   assign is_sub_a_o     = head_a_q.is_sub;
   assign is_sub_b_o     = head_b_q.is_sub;
   assign is_signaling_o = head_a_q.is_snan | head_b_q.is_snan;
   assign class_a_o      = head_a_q.cls;
   assign class_b_o      = head_b_q.cls;
   assign tag_o          = head_tag_q;

endmodule

// File: tb/tb_fpu_operand_unpack.sv
module tb_fpu_operand_unpack;

   localparam int TAG_W = 4;

   logic              clk_i = 1'b0;
   logic              reset_i, flush_i, valid_i, ready_i;
   logic              ready_o, valid_o;
   logic [31:0]       op_a_i, op_b_i;
   logic [TAG_W-1:0]  tag_i, tag_o;
   logic              sign_a_o, sign_b_o;
   logic [7:0]        exp_a_o, exp_b_o;
   logic [23:0]       sig_a_o, sig_b_o;
   logic              is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o;
   logic              is_zero_a_o, is_zero_b_o, is_sub_a_o, is_sub_b_o;
   logic              is_signaling_o;
   logic [9:0]        class_a_o, class_b_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   fpu_operand_unpack #(.TAG_W(TAG_W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .sign_a_o(sign_a_o), .sign_b_o(sign_b_o),
      .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
      .sig_a_o(sig_a_o), .sig_b_o(sig_b_o),
      .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
      .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
      .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
      .is_sub_a_o(is_sub_a_o), .is_sub_b_o(is_sub_b_o),
      .is_signaling_o(is_signaling_o),
      .class_a_o(class_a_o), .class_b_o(class_b_o),
      .tag_o(tag_o)
   );

   // Every data/flag/class/tag output, for all-zero checks after reset.
   logic [98:0] all_data;
   assign all_data = {sign_a_o, sign_b_o, exp_a_o, exp_b_o, sig_a_o, sig_b_o,
                      is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o,
                      is_zero_a_o, is_zero_b_o, is_sub_a_o, is_sub_b_o,
                      is_signaling_o, class_a_o, class_b_o, tag_o};

   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  tag;
      logic        sa;  logic [7:0] ea; logic [23:0] ga; logic [3:0] fa; logic [9:0] ca;
      logic        sb;  logic [7:0] eb; logic [23:0] gb; logic [3:0] fb; logic [9:0] cb;
      logic        snan;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
      valid_i = v;
      op_a_i  = a;
      op_b_i  = b;
      tag_i   = t;
   endtask

   initial begin
      // flags order: {inf, nan, zero, sub}
      vecs[0] = '{32'h3F800000, 32'h00000001, 4'h1,
                  1'b0, 8'h7F, 24'h800000, 4'b0000, 10'h040,
                  1'b0, 8'h00, 24'h000001, 4'b0001, 10'h020, 1'b0};
      vecs[1] = '{32'h7FA00000, 32'hFF800000, 4'h2,
                  1'b0, 8'hFF, 24'hA00000, 4'b0100, 10'h100,
                  1'b1, 8'hFF, 24'h800000, 4'b1000, 10'h001, 1'b1};
      vecs[2] = '{32'h7FC00000, 32'h80000000, 4'h3,
                  1'b0, 8'hFF, 24'hC00000, 4'b0100, 10'h200,
                  1'b1, 8'h00, 24'h000000, 4'b0010, 10'h008, 1'b0};
      vecs[3] = '{32'h00000000, 32'hC0000000, 4'h4,
                  1'b0, 8'h00, 24'h000000, 4'b0010, 10'h010,
                  1'b1, 8'h80, 24'h800000, 4'b0000, 10'h002, 1'b0};
      vecs[4] = '{32'h807FFFFF, 32'h7F800000, 4'h5,
                  1'b1, 8'h00, 24'h7FFFFF, 4'b0001, 10'h004,
                  1'b0, 8'hFF, 24'h800000, 4'b1000, 10'h080, 1'b0};
      vecs[5] = '{32'hFFFFFFFF, 32'h7F800001, 4'h6,
                  1'b1, 8'hFF, 24'hFFFFFF, 4'b0100, 10'h200,
                  1'b0, 8'hFF, 24'h800001, 4'b0100, 10'h100, 1'b1};

      reset_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk_i);
      check("reset_valid", 128'(valid_o), 128'(1'b0));
      check("reset_ready", 128'(ready_o), 128'(1'b1));
      check("reset_data", 128'(all_data), 128'(0));
      reset_i = 1'b0;

      // Classification table: one pair at a time into an empty buffer.
      ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].tag);
         @(negedge clk_i);
         drive(1'b0, 32'h0, 32'h0, 4'h0);
         check($sformatf("v%0d_valid", i), 128'(valid_o), 128'(1'b1));
         check($sformatf("v%0d_fields_a", i), 128'({sign_a_o, exp_a_o, sig_a_o}),
               128'({vecs[i].sa, vecs[i].ea, vecs[i].ga}));
         check($sformatf("v%0d_flags_a", i),
               128'({is_inf_a_o, is_nan_a_o, is_zero_a_o, is_sub_a_o}), 128'(vecs[i].fa));
         check($sformatf("v%0d_class_a", i), 128'(class_a_o), 128'(vecs[i].ca));
         check($sformatf("v%0d_fields_b", i), 128'({sign_b_o, exp_b_o, sig_b_o}),
               128'({vecs[i].sb, vecs[i].eb, vecs[i].gb}));
         check($sformatf("v%0d_flags_b", i),
               128'({is_inf_b_o, is_nan_b_o, is_zero_b_o, is_sub_b_o}), 128'(vecs[i].fb));
         check($sformatf("v%0d_class_b", i), 128'(class_b_o), 128'(vecs[i].cb));
         check($sformatf("v%0d_snan", i), 128'(is_signaling_o), 128'(vecs[i].snan));
         check($sformatf("v%0d_tag", i), 128'(tag_o), 128'(vecs[i].tag));
      end
      @(negedge clk_i);
      check("drain_empty", 128'(valid_o), 128'(1'b0));

      // Backpressure: three pairs offered while downstream stalls.
      ready_i = 1'b0;
      drive(1'b1, 32'h3F800000, 32'h0, 4'h1);
      @(negedge clk_i);
      check("bp_ready_one", 128'(ready_o), 128'(1'b1));
      check("bp_tag_one", 128'(tag_o), 128'(4'h1));
      drive(1'b1, 32'h40000000, 32'h0, 4'h2);
      @(negedge clk_i);
      check("bp_ready_full", 128'(ready_o), 128'(1'b0));
      drive(1'b1, 32'h40400000, 32'h0, 4'h3);
      @(negedge clk_i);
      check("bp_ready_held", 128'(ready_o), 128'(1'b0));
      check("bp_head_stable", 128'({tag_o, exp_a_o}), 128'({4'h1, 8'h7F}));
      ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_out2", 128'({valid_o, tag_o, exp_a_o}), 128'({1'b1, 4'h2, 8'h80}));
      check("bp_ready_free", 128'(ready_o), 128'(1'b1));
      @(negedge clk_i);
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      check("bp_out3", 128'({valid_o, tag_o, exp_a_o}), 128'({1'b1, 4'h3, 8'h80}));
      @(negedge clk_i);
      check("bp_empty", 128'(valid_o), 128'(1'b0));

      // Streaming: eight pairs back to back, one-cycle latency.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h3F800000, 32'h0, 4'(i));
         @(negedge clk_i);
         check($sformatf("stream%0d", i), 128'({valid_o, ready_o, tag_o}),
               128'({1'b1, 1'b1, 4'(i)}));
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk_i);
      check("stream_end", 128'(valid_o), 128'(1'b0));

      // Flush with two entries buffered and a new pair offered.
      ready_i = 1'b0;
      drive(1'b1, 32'h3F800000, 32'h0, 4'hA);
      @(negedge clk_i);
      drive(1'b1, 32'h3F800000, 32'h0, 4'hB);
      @(negedge clk_i);
      check("fl_full", 128'(ready_o), 128'(1'b0));
      flush_i = 1'b1;
      drive(1'b1, 32'h3F800000, 32'h0, 4'hC);
      @(negedge clk_i);
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      check("fl_state", 128'({valid_o, ready_o}), 128'({1'b0, 1'b1}));
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("fl_quiet%0d", i), 128'(valid_o), 128'(1'b0));
      end

      // Reset with one entry buffered.
      ready_i = 1'b0;
      drive(1'b1, 32'hFF800000, 32'h7FA00000, 4'h9);
      @(negedge clk_i);
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      check("rs_one", 128'({valid_o, tag_o}), 128'({1'b1, 4'h9}));
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      check("rs_valid", 128'({valid_o, ready_o}), 128'({1'b0, 1'b1}));
      check("rs_data", 128'(all_data), 128'(0));
      ready_i = 1'b1;
      @(negedge clk_i);
      check("rs_quiet", 128'(valid_o), 128'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
